// File: rtl/mem_responder_if.sv
// Request/response bundle between the multi-cycle controller and the wait-state memory responder.
interface mem_responder_if #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 8
) ();
    logic              mem_read;
    logic              mem_write;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
    logic [DATA_W-1:0] rdata;
    logic              ready;
    logic              busy;
    logic              err;
    logic              fault;

    modport master (
        output mem_read, mem_write, addr, wdata,
        input  rdata, ready, busy, err, fault
    );

    modport slave (
        input  mem_read, mem_write, addr, wdata,
        output rdata, ready, busy, err, fault
    );
endinterface

// File: rtl/mem_responder.sv
// Memory-side responder: serves controller reads/writes from a word array after LATENCY wait cycles.
// Optional write protection of words below PROT_LIMIT is enabled by defining WRITE_PROTECT_EN.
module mem_responder #(
    parameter int DATA_W     = 16,
    parameter int ADDR_W     = 8,
    parameter int LATENCY    = 2,
    parameter int PROT_LIMIT = 16
) (
    input  logic            clk,
    input  logic            rst,
    mem_responder_if.slave  bus
);

`ifdef WRITE_PROTECT_EN
    localparam bit WP_EN = 1'b1;
`else
    localparam bit WP_EN = 1'b0;
`endif

    localparam logic [3:0]      CNT_INIT = 4'(LATENCY - 1);
    localparam logic [ADDR_W:0] PROT_LIM = (ADDR_W + 1)'(PROT_LIMIT);

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        RESP
    } state_t;

    state_t            state;
    state_t            state_nxt;
    logic [3:0]        cnt;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] wdata_q;
    logic              rd_q;
    logic              wr_q;
    logic [DATA_W-1:0] rdata_q;
    logic [DATA_W-1:0] mem [2**ADDR_W];

    logic request;
    logic access;
    logic illegal;
    logic do_read;
    logic do_write;
    logic wr_blocked;

    assign request    = bus.mem_read || bus.mem_write;
    assign access     = (state == WAIT) && (cnt == '0);
    assign illegal    = rd_q && wr_q;
    assign do_read    = rd_q && !wr_q;
    assign wr_blocked = WP_EN && wr_q && !rd_q && ({1'b0, addr_q} < PROT_LIM);
    assign do_write   = wr_q && !rd_q && !wr_blocked;

    // NOTE: every clocked register uses <= so all flops update from pre-edge values,
    // independent of the order the simulator evaluates these blocks.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        // NOTE: default assignment first so no path through the case leaves
        // state_nxt unassigned, which would otherwise infer a latch.
        state_nxt = state;
        unique case (state)
            IDLE:    if (request) state_nxt = WAIT;
            WAIT:    if (cnt == '0) state_nxt = RESP;
            RESP:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        bus.busy  = (state != IDLE);
        bus.ready = 1'b0;
        bus.err   = 1'b0;
        bus.fault = 1'b0;
        if (state == RESP) begin
            bus.ready = 1'b1;
            bus.err   = illegal;
            bus.fault = wr_blocked;
        end
    end

    assign bus.rdata = rdata_q;

    // Request fields are captured only in IDLE; anything the requester does later is ignored.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt     <= '0;
            addr_q  <= '0;
            wdata_q <= '0;
            rd_q    <= 1'b0;
            wr_q    <= 1'b0;
            rdata_q <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (request) begin
                        addr_q  <= bus.addr;
                        wdata_q <= bus.wdata;
                        rd_q    <= bus.mem_read;
                        wr_q    <= bus.mem_write;
                        cnt     <= CNT_INIT;
                    end
                end
                WAIT: begin
                    if (cnt != '0) begin
                        cnt <= cnt - 4'd1;
                    end else if (do_read) begin
                        rdata_q <= mem[addr_q];
                    end
                end
                default: ;
            endcase
        end
    end

    // NOTE: the storage array has no reset; clearing it would defeat RAM inference.
    // An async reset still drops the state to IDLE, so an aborted write never lands.
    always_ff @(posedge clk) begin
        if (access && do_write) begin
            mem[addr_q] <= wdata_q;
        end
    end

endmodule

// File: tb/tb_mem_responder.sv
// Self-checking bench for mem_responder: directed scenarios plus random traffic against a transaction-level model.
module tb_mem_responder;
    localparam int DW  = 16;
    localparam int AW  = 8;
    localparam int LAT = 2;
    localparam int PL  = 16;

`ifdef WRITE_PROTECT_EN
    localparam bit WP = 1'b1;
`else
    localparam bit WP = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst;
    int   total = 0;
    int   bad   = 0;

    mem_responder_if #(.DATA_W(DW), .ADDR_W(AW)) bus ();

    mem_responder #(
        .DATA_W(DW), .ADDR_W(AW), .LATENCY(LAT), .PROT_LIMIT(PL)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    // Transaction-level model: word array, per-word "content known" flag, and the last read value.
    logic [DW-1:0] ref_mem   [2**AW];
    bit            ref_known [2**AW];
    logic [DW-1:0] ref_rdata;
    bit            ref_rd_known;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic drop_req();
        bus.mem_read  = 1'b0;
        bus.mem_write = 1'b0;
    endtask

    // One complete request: predict, drive, wait (bounded) for ready, check, release, check idle.
    task automatic xact(input bit rd, input bit wr, input logic [AW-1:0] a,
                        input logic [DW-1:0] d, input bit disturb);
        int cyc;
        bit exp_err;
        bit exp_fault;

        exp_err   = rd && wr;
        exp_fault = WP && wr && !rd && (int'(a) < PL);
        if (rd && !wr) begin
            ref_rdata    = ref_mem[a];
            ref_rd_known = ref_known[a];
        end
        if (wr && !rd && !exp_fault) begin
            ref_mem[a]   = d;
            ref_known[a] = 1'b1;
        end

        @(negedge clk);
        bus.mem_read  = rd;
        bus.mem_write = wr;
        bus.addr      = a;
        bus.wdata     = d;
        cyc = 0;
        do begin
            @(posedge clk);
            #1;
            cyc++;
            if (!bus.ready) check("busy_wait", bus.busy, 1);
            if (disturb && cyc == 1) begin
                bus.addr      = a ^ 8'h01;
                bus.mem_write = 1'b1;
                bus.wdata     = ~d;
            end
        end while (!bus.ready && cyc < 40);

        check("latency", cyc, LAT + 1);
        check("busy_resp", bus.busy, 1);
        check("err", bus.err, exp_err);
        check("fault", bus.fault, exp_fault);
        if (ref_rd_known) check("rdata", bus.rdata, ref_rdata);

        @(negedge clk);
        drop_req();
        @(posedge clk);
        #1;
        check("ready_drop", bus.ready, 0);
        check("busy_idle", bus.busy, 0);
        check("err_idle", bus.err, 0);
        if (ref_rd_known) check("rdata_hold", bus.rdata, ref_rdata);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst           = 1'b1;
        bus.mem_read  = 1'b0;
        bus.mem_write = 1'b0;
        bus.addr      = '0;
        bus.wdata     = '0;
        for (int i = 0; i < 2**AW; i++) ref_known[i] = 1'b0;
        ref_rdata    = '0;
        ref_rd_known = 1'b1;

        repeat (3) @(posedge clk);
        #1;
        check("rst_rdata", bus.rdata, 0);
        check("rst_ready", bus.ready, 0);
        check("rst_busy", bus.busy, 0);
        check("rst_err", bus.err, 0);
        check("rst_fault", bus.fault, 0);
        @(negedge clk);
        rst = 1'b0;

        // Preload every word so later reads have a defined expectation.
        for (int i = 0; i < 2**AW; i++) begin
            xact(1'b0, 1'b1, AW'(i), (i == 'h40) ? 16'h5A5A : DW'($urandom), 1'b0);
        end

        // Reset in the first WAIT cycle of a write aborts it without touching the array.
        @(negedge clk);
        bus.mem_write = 1'b1;
        bus.addr      = 8'h40;
        bus.wdata     = 16'hBEEF;
        @(posedge clk);
        #1;
        check("abort_busy_pre", bus.busy, 1);
        rst = 1'b1;
        #1;
        check("abort_busy", bus.busy, 0);
        check("abort_ready", bus.ready, 0);
        check("abort_rdata", bus.rdata, 0);
        drop_req();
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        ref_rdata    = '0;
        ref_rd_known = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(posedge clk);
            #1;
            check("abort_no_ready", bus.ready, 0);
        end
        xact(1'b1, 1'b0, 8'h40, 16'h0000, 1'b0);

        // Plain write/read, then a read disturbed while busy, then neighbour checks.
        xact(1'b0, 1'b1, 8'h20, 16'h1234, 1'b0);
        xact(1'b1, 1'b0, 8'h20, 16'h0000, 1'b0);
        xact(1'b1, 1'b0, 8'h20, 16'h5555, 1'b1);
        xact(1'b1, 1'b0, 8'h21, 16'h0000, 1'b0);
        xact(1'b1, 1'b0, 8'h20, 16'h0000, 1'b0);

        // Illegal request must leave both the array and rdata alone.
        xact(1'b1, 1'b1, 8'h30, 16'hDEAD, 1'b0);
        xact(1'b1, 1'b0, 8'h30, 16'h0000, 1'b0);

        // Back-to-back at the address-space extremes.
        xact(1'b0, 1'b1, 8'hFF, 16'hC0DE, 1'b0);
        xact(1'b0, 1'b1, 8'h00, 16'h0F0F, 1'b0);
        xact(1'b1, 1'b0, 8'hFF, 16'h0000, 1'b0);
        xact(1'b1, 1'b0, 8'h00, 16'h0000, 1'b0);

        // Protection boundary.
        xact(1'b0, 1'b1, 8'h0F, 16'hAAAA, 1'b0);
        xact(1'b1, 1'b0, 8'h0F, 16'h0000, 1'b0);
        check("wp_0f_stored", 32'(bus.rdata == 16'hAAAA), 32'(!WP));
        xact(1'b0, 1'b1, 8'h10, 16'hAAAA, 1'b0);
        xact(1'b1, 1'b0, 8'h10, 16'h0000, 1'b0);

        // Random traffic.
        for (int n = 0; n < 80; n++) begin
            int op;
            op = int'($urandom_range(0, 99));
            xact(op < 50 || op >= 85, op >= 50, AW'($urandom), DW'($urandom),
                 $urandom_range(0, 3) == 0);
            repeat ($urandom_range(0, 2)) @(posedge clk);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/mem_responder.md
Name: mem_responder

Overview:
- Memory-side responder for the multi-cycle MIPS controller's memory interface.
- The controller drives mem_read or mem_write with an address and write data. This block serves the request from an internal word array after a configurable latency, then pulses ready.
- Replaces the zero-wait ideal memory so the controller can be exercised against wait states. Sits between the controller/datapath address mux (IOrD) and the storage array.

Parameters:
DATA_W, 16, word width in bits
ADDR_W, 8, word-address width; array depth is 2**ADDR_W words
LATENCY, 2, wait cycles before access completes; legal range 1..15
PROT_LIMIT, 16, first writable word address (used only with WRITE_PROTECT_EN)

Ports:
clk  in  1  clock, rising edge
rst  in  1  reset, asynchronous, active-high
mem_read  in  1  read request level; held by requester until ready
mem_write  in  1  write request level; held by requester until ready
addr  in  ADDR_W  word address
wdata  in  DATA_W  write data
rdata  out  DATA_W  registered read data
ready  out  1  one-cycle completion pulse
busy  out  1  high whenever state is not IDLE
err  out  1  one-cycle pulse with ready when the request was illegal
fault  out  1  one-cycle pulse with ready when a write was blocked (WRITE_PROTECT_EN only; tied 0 otherwise)

Behaviour:
- Reset values: state=IDLE, cnt=0, rdata=0, ready=0, busy=0, err=0, fault=0. Array contents are not reset.
- FSM states:
  - IDLE: if mem_read or mem_write is high at a rising edge, latch addr, wdata, the read/write ops and the illegal flag (both high). Then go to WAIT with cnt=LATENCY-1. Otherwise stay in IDLE.
  - WAIT: if cnt==0, perform the access at this edge and go to RESP. Otherwise decrement cnt.
  - RESP: ready=1 (plus err/fault as applicable) for exactly one cycle, then unconditionally go to IDLE.
- Latency: request first visible in cycle N -> ready high in cycle N+LATENCY+1. For LATENCY=2, ready appears 3 cycles after the request.
- Access at the WAIT->RESP edge:
  - read: rdata <= mem[addr_latched].
  - write: mem[addr_latched] <= wdata_latched; rdata unchanged.
- Inputs are sampled only in IDLE. Changes to addr/wdata/request during WAIT or RESP are ignored.
- The requester must drop the request in the cycle ready is high. A request still high in the following IDLE cycle is a new request.
- Both mem_read and mem_write high at capture: no array access, rdata unchanged, err=1 together with ready.
- rdata holds its value until the next successful read completes.
- Reset during WAIT or RESP: immediate return to IDLE with reset output values. A pending write is discarded and the array is untouched.
- Address space is exactly 2**ADDR_W words: no out-of-range case, no wrap logic.
- Back-to-back requests: minimum issue spacing is LATENCY+2 cycles.

Optional Feature:
- Macro WRITE_PROTECT_EN.
- Defined: writes with addr_latched < PROT_LIMIT are suppressed (array unchanged) and fault=1 with ready. Reads are always permitted. err takes precedence: when both ops are high, only err is asserted.
- Undefined: fault is constant 0 and all writes are stored; PROT_LIMIT is unused.

Test Plan:
- Reset mid-WAIT: issue write of 0xBEEF to 0x40, assert rst in the first WAIT cycle, then read 0x40 -> ready 3 cycles after the read request, rdata equals the pre-test content (not 0xBEEF), no ready pulse from the aborted write.
- Write/read latency, LATENCY=2: write 0x1234 to 0x20 -> ready exactly 3 cycles after request, busy high for 3 cycles. Then read 0x20 -> rdata=0x1234 in the ready cycle, held afterwards.
- Input changes while busy: during WAIT of a read from 0x20, change addr to 0x21 and raise mem_write -> still returns mem[0x20], no write occurs, err=0.
- Illegal request: mem_read=mem_write=1 at 0x30 -> ready with err=1, mem[0x30] unchanged, rdata unchanged.
- Back-to-back: controller drops request on ready, re-requests next cycle for 0xFF and 0x00 -> both complete correctly, no missed or duplicated ready.
- WRITE_PROTECT_EN, PROT_LIMIT=16: write 0xAAAA to 0x0F -> fault=1 with ready, readback unchanged. Write to 0x10 -> fault=0, readback 0xAAAA. Without the macro, the same write to 0x0F is stored and fault stays 0.
